// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and FSM state encodings for the default-slave block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   RESP_OKAY / RESP_DECERR : AXI response codes
//   wr_state_t              : write-channel FSM encoding (idle, data, response)
//   rd_state_t              : read-channel FSM encoding (idle, data)
//   BEAT_CNT_WIDTH          : width of the read burst beat counter (AXI4 arlen)
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BEAT_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_default_slave_rd.sv
// Read engine of the default slave: accepts one AR, returns arlen+1 DECERR beats with zero data.
// Latency: first rvalid the cycle after the AR handshake, then one beat per cycle while rready=1.
// Backpressure: rready low holds the current beat (rid/rlast/rresp/rdata) unchanged; AR is only
//               accepted in idle, so a new burst waits until the last beat has been taken.
//
// Ports:
//   aclk, areset                : clock, synchronous active-high reset
//   arid, arlen, arvalid/arready: AR channel (address is not needed, so it is not a port)
//   rid, rdata, rresp, rlast,
//   rvalid/rready               : R channel
//   last_hs                     : pulses in the cycle where the rlast beat is handshaken
module axi4_default_slave_rd
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  last_hs
);

    rd_state_t                 state;
    rd_state_t                 state_nxt;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
    logic [ID_WIDTH-1:0]       captured_id;

    // Counter holds the number of beats still to send after the current one,
    // so zero marks the final beat.
    logic cnt_zero;
    assign cnt_zero = (beat_cnt == '0);

    // State register plus the per-burst datapath registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= RD_IDLE;
            beat_cnt    <= '0;
            captured_id <= '0;
        end else begin
            state <= state_nxt;
            if (state == RD_IDLE) begin
                if (arvalid) begin
                    beat_cnt    <= arlen;
                    captured_id <= arid;
                end
            end else if (rready && !cnt_zero) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (state == RD_IDLE) begin
            if (arvalid) begin
                state_nxt = RD_DATA;
            end
        end else begin
            if (rready && cnt_zero) begin
                state_nxt = RD_IDLE;
            end
        end
    end

    // Outputs decode only registered state, so nothing on the R/AR outputs
    // depends combinationally on any input.
    always_comb begin
        arready = (state == RD_IDLE);
        rvalid  = (state == RD_DATA);
        rlast   = (state == RD_DATA) && cnt_zero;
        rresp   = (state == RD_DATA) ? RESP_DECERR : RESP_OKAY;
        rid     = captured_id;
        rdata   = '0;
    end

    // Internal strobe for the completion counter in the parent.
    assign last_hs = rvalid && rready && rlast;

endmodule

// File: rtl/axi4_default_slave.sv
// AXI4 default slave: terminates unmapped/erroneous transactions with DECERR and counts them.
// Latency: wready 1 cycle after AW, bvalid 1 cycle after wlast beat, rvalid 1 cycle after AR.
// Backpressure: bready/rready low hold B/R stable; AW/AR/W are accepted only in the matching state.
//
// Ports:
//   aclk, areset                    : clock, synchronous active-high reset
//   awid, awvalid/awready           : AW channel (address not needed)
//   wlast, wvalid/wready            : W channel (data/strobes discarded, so not ports)
//   bid, bresp, bvalid/bready       : B channel
//   arid, arlen, arvalid/arready    : AR channel
//   rid, rdata, rresp, rlast,
//   rvalid/rready                   : R channel
//   decerr_count                    : saturating count of completed DECERR transactions
module axi4_default_slave
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [CNT_WIDTH-1:0]  decerr_count
);

    // ------------------------------------------------------------------
    // Write FSM: idle -> swallow beats until wlast -> DECERR response.
    // ------------------------------------------------------------------
    wr_state_t           wr_state;
    wr_state_t           wr_state_nxt;
    logic [ID_WIDTH-1:0] captured_awid;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state      <= WR_IDLE;
            captured_awid <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            if (wr_state == WR_IDLE && awvalid) begin
                captured_awid <= awid;
            end
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE: if (awvalid)          wr_state_nxt = WR_DATA;
            WR_DATA: if (wvalid && wlast)  wr_state_nxt = WR_RESP;
            WR_RESP: if (bready)           wr_state_nxt = WR_IDLE;
            default:                       wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        awready = (wr_state == WR_IDLE);
        wready  = (wr_state == WR_DATA);
        bvalid  = (wr_state == WR_RESP);
        bresp   = (wr_state == WR_RESP) ? RESP_DECERR : RESP_OKAY;
        bid     = captured_awid;
    end

    // ------------------------------------------------------------------
    // Read engine.
    // ------------------------------------------------------------------
    logic r_last_hs;

    axi4_default_slave_rd #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd (
        .aclk    (aclk),
        .areset  (areset),
        .arid    (arid),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .last_hs (r_last_hs)
    );

    // ------------------------------------------------------------------
    // Completion counter. A write and a read can finish in the same cycle,
    // so the increment is 0..2; one extra sum bit detects overflow and the
    // result clamps to all-ones instead of wrapping.
    // ------------------------------------------------------------------
    logic                 b_hs;
    logic [1:0]           cnt_inc;
    logic [CNT_WIDTH:0]   cnt_sum;

    assign b_hs    = bvalid && bready;
    assign cnt_inc = {1'b0, b_hs} + {1'b0, r_last_hs};
    assign cnt_sum = {1'b0, decerr_count} + {{(CNT_WIDTH-1){1'b0}}, cnt_inc};

    always_ff @(posedge aclk) begin
        if (areset) begin
            decerr_count <= '0;
        end else if (cnt_sum[CNT_WIDTH]) begin
            decerr_count <= '1;
        end else begin
            decerr_count <= cnt_sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_axi4_default_slave.sv
// Testbench for axi4_default_slave: directed sequence with randomized gaps/backpressure,
// checked against a transaction-level expectation (beats per burst, IDs, saturating count).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi4_default_slave;

    localparam int IDW     = 4;
    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [IDW-1:0]  awid = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic            wlast = 1'b0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [IDW-1:0]  arid = '0;
    logic [7:0]      arlen = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [IDW-1:0]  rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [CW-1:0]   decerr_count;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    int w_hs_cnt = 0;

    always #5 aclk = ~aclk;

    axi4_default_slave #(
        .ID_WIDTH   (IDW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .awid         (awid),
        .awvalid      (awvalid),
        .awready      (awready),
        .wlast        (wlast),
        .wvalid       (wvalid),
        .wready       (wready),
        .bid          (bid),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .arid         (arid),
        .arlen        (arlen),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .decerr_count (decerr_count)
    );

    // Counts W handshakes as the DUT sees them at the clock edge.
    always @(posedge aclk) begin
        if (!areset && wvalid && wready) w_hs_cnt <= w_hs_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every finished transaction adds one to the count, clamped at all-ones.
    task automatic model_complete(input int k);
        model_count = (model_count + k > CNT_MAX) ? CNT_MAX : model_count + k;
    endtask

    // All tasks start and end positioned at a falling edge.
    task automatic finish_b(input logic [IDW-1:0] id);
        int stall;
        stall = $urandom_range(0, 3);
        repeat (stall) begin
            bready = 1'b0;
            chk("b_stall_bvalid", bvalid, 1'b1);
            chk("b_stall_bid", bid, id);
            chk("b_stall_bresp", bresp, 2'b11);
            @(negedge aclk);
        end
        bready = 1'b1;
        chk("bvalid", bvalid, 1'b1);
        chk("bid", bid, id);
        chk("bresp", bresp, 2'b11);
        @(negedge aclk);
        bready = 1'b0;
        model_complete(1);
        chk("bvalid_after_hs", bvalid, 1'b0);
        chk("awready_after_b", awready, 1'b1);
        chk("count_after_write", decerr_count, model_count[CW-1:0]);
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input int nbeats, input bit release_b);
        int n;
        int hs_start;
        awid = id;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge aclk); n++; end
        chk("aw_timeout", n >= 100, 1'b0);
        @(negedge aclk);
        awvalid = 1'b0;
        awid = IDW'($urandom);
        chk("wready_latency", wready, 1'b1);
        hs_start = w_hs_cnt;
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(0, 2)) begin
                wvalid = 1'b0;
                wlast = 1'b0;
                @(negedge aclk);
            end
            wvalid = 1'b1;
            wlast = (i == nbeats - 1);
            n = 0;
            while (!wready && n < 100) begin @(negedge aclk); n++; end
            chk("w_timeout", n >= 100, 1'b0);
            @(negedge aclk);
        end
        // Keep offering a beat after wlast: it must not be taken.
        wlast = 1'b0;
        chk("wready_after_last", wready, 1'b0);
        chk("bvalid_latency", bvalid, 1'b1);
        @(negedge aclk);
        wvalid = 1'b0;
        chk("w_handshakes", w_hs_cnt - hs_start, nbeats);
        if (release_b) finish_b(id);
    endtask

    task automatic send_ar(input logic [IDW-1:0] id, input int len);
        int n;
        arid = id;
        arlen = 8'(len);
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge aclk); n++; end
        chk("ar_timeout", n >= 100, 1'b0);
        @(negedge aclk);
        arvalid = 1'b0;
        arid = IDW'($urandom);
        arlen = 8'($urandom);
        chk("rvalid_latency", rvalid, 1'b1);
    endtask

    // mode 0: rready always high; 1: alternate 1/0; 2: random
    task automatic do_read(input logic [IDW-1:0] id, input int len, input int mode);
        int beat;
        int cyc;
        bit prev_stall;
        logic [IDW-1:0] p_rid;
        logic p_rlast;
        logic p_rvalid;
        send_ar(id, len);
        beat = 0;
        cyc = 0;
        prev_stall = 1'b0;
        p_rid = '0;
        p_rlast = 1'b0;
        p_rvalid = 1'b0;
        while (beat <= len && cyc < 2000) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 2 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            chk("rvalid", rvalid, 1'b1);
            if (!rvalid) break;
            chk("rid", rid, id);
            chk("rdata", rdata, '0);
            chk("rresp", rresp, 2'b11);
            chk("rlast", rlast, beat == len);
            if (prev_stall) begin
                chk("stall_rid", rid, p_rid);
                chk("stall_rlast", rlast, p_rlast);
                chk("stall_rvalid", rvalid, p_rvalid);
            end
            prev_stall = !rready;
            p_rid = rid;
            p_rlast = rlast;
            p_rvalid = rvalid;
            if (rready) beat++;
            cyc++;
            @(negedge aclk);
        end
        rready = 1'b0;
        chk("r_beats", beat, len + 1);
        model_complete(1);
        chk("rvalid_after_burst", rvalid, 1'b0);
        chk("arready_after_burst", arready, 1'b1);
        chk("count_after_read", decerr_count, model_count[CW-1:0]);
    endtask

    initial begin
        // Reset and post-reset output values.
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        chk("rst_awready", awready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_bid", bid, '0);
        chk("rst_rid", rid, '0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, '0);
        chk("rst_count", decerr_count, '0);
        areset = 1'b0;

        // A W beat with no preceding AW is never accepted.
        wvalid = 1'b1;
        wlast = 1'b1;
        chk("idle_w_wready", wready, 1'b0);
        @(negedge aclk);
        chk("idle_w_wready2", wready, 1'b0);
        chk("idle_w_bvalid", bvalid, 1'b0);
        chk("idle_w_hs", w_hs_cnt, 0);
        wvalid = 1'b0;
        wlast = 1'b0;

        // Write: id 3, four beats.
        do_write(4'd3, 4, 1'b1);

        // Read: id 5, eight beats, no backpressure.
        do_read(4'd5, 7, 0);

        // Read: four beats with rready toggling.
        do_read(IDW'($urandom), 3, 1);

        // B and final R handshakes in the same cycle.
        do_write(4'd9, 1, 1'b0);
        rready = 1'b0;
        send_ar(4'd2, 0);
        chk("coin_rlast", rlast, 1'b1);
        chk("coin_count_before", decerr_count, model_count[CW-1:0]);
        bready = 1'b1;
        rready = 1'b1;
        chk("coin_bvalid", bvalid, 1'b1);
        chk("coin_rvalid", rvalid, 1'b1);
        @(negedge aclk);
        bready = 1'b0;
        rready = 1'b0;
        model_complete(2);
        chk("coin_count_after", decerr_count, model_count[CW-1:0]);
        chk("coin_idle_b", bvalid, 1'b0);
        chk("coin_idle_r", rvalid, 1'b0);

        // Reset during the second beat of a 16-beat burst.
        send_ar(4'd6, 15);
        rready = 1'b1;
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        model_count = 0;
        chk("mid_rst_arready", arready, 1'b1);
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_rlast", rlast, 1'b0);
        chk("mid_rst_rid", rid, '0);
        chk("mid_rst_count", decerr_count, '0);
        repeat (3) begin
            @(negedge aclk);
            chk("mid_rst_no_beat", rvalid, 1'b0);
        end
        rready = 1'b0;
        do_read(4'd7, 2, 2);

        // Fill the counter to saturation with a mix of transactions,
        // including a maximum-length 256-beat burst.
        do_read(IDW'($urandom), 255, 0);
        for (int i = 0; i < 13; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(IDW'($urandom), $urandom_range(1, 3), 1'b1);
            else
                do_read(IDW'($urandom), $urandom_range(0, 3), 2);
        end
        chk("count_full", decerr_count, model_count[CW-1:0]);
        do_write(4'd1, 2, 1'b1);
        do_read(4'd14, 1, 2);
        chk("count_saturated", decerr_count, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
